// File: rtl/trace_pkg.sv
// Shared types and default sizing for the write-back trace buffer.
package trace_pkg;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int SEQ_W  = 16;

    // One captured write-back event: tag, destination register, data.
    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: synchronous write, asynchronous read, no reset.
module trace_ram
    import trace_pkg::*;
#(
    parameter int  DEPTH   = trace_pkg::DEPTH,
    parameter type entry_t = trace_entry_t,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  entry_t           wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output entry_t           rdata_o
);

    entry_t mem_q [DEPTH];

    // Store the incoming entry at the write pointer.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace FIFO: tags each register write with a sequence number,
// drops (and counts) writes when full rather than stalling the core.
module wb_trace_buffer #(
    parameter int  DEPTH  = trace_pkg::DEPTH,
    parameter int  DATA_W = trace_pkg::DATA_W,
    parameter int  ADDR_W = trace_pkg::ADDR_W,
    parameter int  SEQ_W  = trace_pkg::SEQ_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              freeze_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [SEQ_W-1:0]  out_seq_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              overflow_o,
    output logic [SEQ_W-1:0]  drop_cnt_o
);

    // Mirrors trace_pkg::trace_entry_t but follows this instance's widths.
    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    logic   push_req_s, pop_s, full_s, push_ok_s, drop_s, nonempty_s;
    entry_t wr_entry_s, head_s;

    assign nonempty_s = (level_q != {LVL_W{1'b0}});
    assign full_s     = (level_q == LVL_W'(DEPTH));
    assign push_req_s = wb_valid_i & ~freeze_i;
    assign pop_s      = nonempty_s & out_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok_s  = push_req_s & (~full_s | pop_s);
    assign drop_s     = push_req_s & full_s & ~pop_s;

    assign wr_entry_s = '{seq: seq_q, addr: wb_addr_i, data: wb_data_i};

    trace_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push_ok_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_s)
    );

    // Next-state for pointers, occupancy, sequence tag and drop accounting.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        seq_d       = seq_q;
        drop_cnt_d  = drop_cnt_q;
        overflow_d  = overflow_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // Tag advances on every request so consumers see gaps for drops.
        if (push_req_s) begin
            seq_d = seq_q + SEQ_W'(1);
        end else begin
            seq_d = seq_q;
        end
        if (drop_s) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {SEQ_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + SEQ_W'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Control state registers; reset discards all buffered entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= {LVL_W{1'b0}};
            seq_q      <= {SEQ_W{1'b0}};
            drop_cnt_q <= {SEQ_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Head fields read zero while empty, which also covers the reset state
    // of the unreset storage array.
    assign out_valid_o = nonempty_s;
    assign out_seq_o   = nonempty_s ? head_s.seq  : {SEQ_W{1'b0}};
    assign out_addr_o  = nonempty_s ? head_s.addr : {ADDR_W{1'b0}};
    assign out_data_o  = nonempty_s ? head_s.data : {DATA_W{1'b0}};
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: queue-based reference model plus
// a vector table and hand-written corner-case sequences.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, freeze, out_ready;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, overflow;
    logic [15:0] out_seq, drop_cnt;
    logic [5:0]  out_addr;
    logic [31:0] out_data;
    logic [4:0]  level;

    wb_trace_buffer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wb_valid_i  (wb_valid),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .freeze_i    (freeze),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_seq_o   (out_seq),
        .out_addr_o  (out_addr),
        .out_data_o  (out_data),
        .level_o     (level),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] seq;
        logic [5:0]  addr;
        logic [31:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [15:0] m_seq;
    logic [15:0] m_drop;
    logic        m_ovf;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_seq  = 16'd0;
        m_drop = 16'd0;
        m_ovf  = 1'b0;
    endtask

    // Drive one cycle's inputs (called just after a falling edge), check the
    // head against the scoreboard, and advance the model.
    task automatic drive_pre(input logic v, input logic [5:0] a, input logic [31:0] d,
                             input logic f, input logic r);
        sb_t e;
        bit  m_pop, m_push;
        wb_valid  = v;
        wb_addr   = a;
        wb_data   = d;
        freeze    = f;
        out_ready = r;
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
        if (sb.size() != 0) begin
            chk("head_seq",  {48'd0, out_seq},  {48'd0, sb[0].seq});
            chk("head_addr", {58'd0, out_addr}, {58'd0, sb[0].addr});
            chk("head_data", {32'd0, out_data}, {32'd0, sb[0].data});
        end
        m_pop  = (sb.size() != 0) && r;
        m_push = v && !f;
        if (m_pop) void'(sb.pop_front());
        if (m_push) begin
            if (sb.size() < DEPTH) begin
                e.seq  = m_seq;
                e.addr = a;
                e.data = d;
                sb.push_back(e);
            end else begin
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                m_ovf = 1'b1;
            end
            m_seq = m_seq + 16'd1;
        end
    endtask

    // Clock the cycle and compare occupancy and drop accounting.
    task automatic finish_cycle();
        @(posedge clk);
        #1;
        chk("level",    {59'd0, level},    64'(sb.size()));
        chk("drop_cnt", {48'd0, drop_cnt}, {48'd0, m_drop});
        chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic [5:0] a, input logic [31:0] d,
                        input logic f, input logic r);
        drive_pre(v, a, d, f, r);
        finish_cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_level", {59'd0, level},     64'd0);
        chk("rst_seq",   {48'd0, out_seq},   64'd0);
        chk("rst_addr",  {58'd0, out_addr},  64'd0);
        chk("rst_data",  {32'd0, out_data},  64'd0);
        chk("rst_drop",  {48'd0, drop_cnt},  64'd0);
        chk("rst_ovf",   {63'd0, overflow},  64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic [5:0]  a;
        logic [31:0] d;
        logic        r;
        logic        exp_valid_pre;
        logic [15:0] exp_seq_pre;
        logic [5:0]  exp_addr_pre;
        logic [31:0] exp_data_pre;
        int          exp_level_post;
    } vec_t;

    vec_t vecs[6];

    initial begin
        rst_n     = 1'b0;
        wb_valid  = 1'b0;
        wb_addr   = 6'd0;
        wb_data   = 32'd0;
        freeze    = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // Three pushes with the consumer stalled, then three pops.
        vecs[0] = '{1'b1, 6'd1, 32'hA, 1'b0, 1'b0, 16'd0, 6'd0, 32'h0, 1};
        vecs[1] = '{1'b1, 6'd2, 32'hB, 1'b0, 1'b1, 16'd0, 6'd1, 32'hA, 2};
        vecs[2] = '{1'b1, 6'd3, 32'hC, 1'b0, 1'b1, 16'd0, 6'd1, 32'hA, 3};
        vecs[3] = '{1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 16'd0, 6'd1, 32'hA, 2};
        vecs[4] = '{1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 16'd1, 6'd2, 32'hB, 1};
        vecs[5] = '{1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 16'd2, 6'd3, 32'hC, 0};

        do_reset();

        for (int i = 0; i < 6; i++) begin
            drive_pre(vecs[i].v, vecs[i].a, vecs[i].d, 1'b0, vecs[i].r);
            chk("vec_valid", {63'd0, out_valid}, {63'd0, vecs[i].exp_valid_pre});
            chk("vec_seq",   {48'd0, out_seq},   {48'd0, vecs[i].exp_seq_pre});
            chk("vec_addr",  {58'd0, out_addr},  {58'd0, vecs[i].exp_addr_pre});
            chk("vec_data",  {32'd0, out_data},  {32'd0, vecs[i].exp_data_pre});
            finish_cycle();
            chk("vec_level", {59'd0, level}, 64'(vecs[i].exp_level_post));
        end
        chk("vec_end_valid", {63'd0, out_valid}, 64'd0);

        // Overfill: 20 pushes into 16 slots.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 6'(i), 32'h1000 + 32'(i), 1'b0, 1'b0);
        chk("fill_level", {59'd0, level},    64'd16);
        chk("fill_drop",  {48'd0, drop_cnt}, 64'd4);
        chk("fill_ovf",   {63'd0, overflow}, 64'd1);
        chk("fill_head",  {48'd0, out_seq},  64'd0);

        // Push and pop together at full: no drop, new entry (seq 20) at tail.
        step(1'b1, 6'd33, 32'hF00D, 1'b0, 1'b1);
        chk("fullpp_level", {59'd0, level},    64'd16);
        chk("fullpp_drop",  {48'd0, drop_cnt}, 64'd4);
        for (int i = 0; i < 15; i++) step(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
        chk("tail_seq",  {48'd0, out_seq},  64'd20);
        chk("tail_data", {32'd0, out_data}, 64'h0000F00D);
        step(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);

        // Sustained push+pop at level 1 across two pointer wraps.
        step(1'b1, 6'd5, 32'h5555, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 6'($urandom_range(0, 63)), $urandom, 1'b0, 1'b1);
            chk("stream_level", {59'd0, level}, 64'd1);
        end
        chk("stream_drop", {48'd0, drop_cnt}, 64'd4);
        step(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);

        // Freeze while draining: writes ignored, tag does not advance.
        for (int i = 0; i < 4; i++) step(1'b1, 6'(10 + i), 32'h700 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 6'd63, 32'hDEAD, 1'b1, 1'b1);
        chk("frz_level", {59'd0, level}, 64'd0);
        step(1'b1, 6'd9, 32'h9999, 1'b0, 1'b0);
        // 20 fill + 1 + 1 + 40 + 4 requests so far
        chk("frz_seq", {48'd0, out_seq}, 64'd66);
        step(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);

        // Async reset mid-stream at level 7 with drops recorded.
        for (int i = 0; i < 23; i++) step(1'b1, 6'(i), 32'h2000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
        chk("pre_rst_level", {59'd0, level},    64'd7);
        chk("pre_rst_drop",  {48'd0, drop_cnt}, 64'd11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_level", {59'd0, level},     64'd0);
        chk("arst_drop",  {48'd0, drop_cnt},  64'd0);
        chk("arst_ovf",   {63'd0, overflow},  64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 6'd7, 32'h7777, 1'b0, 1'b0);
        chk("post_rst_seq", {48'd0, out_seq}, 64'd0);
        step(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
